// File: rtl/unidad_busqueda_pkg.sv
// Shared definitions for the instruction fetch unit: reset values,
// PC step, FSM state encoding and the FIFO entry layout.
package paquete_busqueda;

    localparam logic [31:0] PC_REINICIO = 32'h0000_0000;
    localparam logic [31:0] NOP         = 32'h0000_0000;
    localparam logic [31:0] PASO_PC     = 32'd4;

    // OCIOSO: nothing outstanding; ESPERA: response kept; DESCARTE: response dropped
    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ESPERA   = 2'd1,
        DESCARTE = 2'd2
    } estado_t;

    // One buffered instruction together with the address it was fetched from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entrada_t;

    // Sequential fetch address; wraps naturally modulo 2^32
    function automatic logic [31:0] siguiente_pc(input logic [31:0] pc);
        return pc + PASO_PC;
    endfunction

endpackage

// File: rtl/unidad_busqueda_if.sv
// Bus bundle of the fetch unit: instruction-memory side, redirect input
// and the offer to the decode pipeline register.
interface unidad_busqueda_if;

    logic        detener;
    logic        salto_valido;
    logic [31:0] salto_destino;
    logic        mem_req;
    logic [31:0] mem_dir;
    logic        mem_listo;
    logic [31:0] mem_dato;
    logic [31:0] instruccion_salida;
    logic [31:0] pc_salida;
    logic        valido_salida;

    // Fetch unit side
    modport master (
        input  detener,
        input  salto_valido,
        input  salto_destino,
        input  mem_listo,
        input  mem_dato,
        output mem_req,
        output mem_dir,
        output instruccion_salida,
        output pc_salida,
        output valido_salida
    );

    // Memory / pipeline side
    modport slave (
        output detener,
        output salto_valido,
        output salto_destino,
        output mem_listo,
        output mem_dato,
        input  mem_req,
        input  mem_dir,
        input  instruccion_salida,
        input  pc_salida,
        input  valido_salida
    );

endinterface

// File: rtl/unidad_busqueda_fifo.sv
// Two-entry FIFO holding {pc, instruction} pairs between memory and decode.
// Flush has priority over push/pop; a push into a full FIFO is accepted
// only when the head is popped in the same cycle.
module fifo_busqueda (
    input  logic        clk,
    input  logic        reinicio,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [63:0] dato_entrada,
    output logic [63:0] dato_cabeza,
    output logic [1:0]  ocupacion
);

    logic [63:0] mem_r [2];
    logic        ptr_esc_r;
    logic        ptr_lec_r;
    logic [1:0]  ocup_r;
    logic        push_ef_s;
    logic        pop_ef_s;

    // Qualify push/pop against the current occupancy
    always_comb begin
        push_ef_s = 1'b0;
        pop_ef_s  = 1'b0;
        if (flush) begin
            push_ef_s = 1'b0;
            pop_ef_s  = 1'b0;
        end else begin
            push_ef_s = push && ((ocup_r != 2'd2) || pop);
            pop_ef_s  = pop && (ocup_r != 2'd0);
        end
    end

    // Pointers and occupancy counter
    always_ff @(posedge clk) begin
        if (reinicio || flush) begin
            ptr_esc_r <= 1'b0;
            ptr_lec_r <= 1'b0;
            ocup_r    <= 2'd0;
        end else begin
            if (push_ef_s) begin
                ptr_esc_r <= ~ptr_esc_r;
            end else begin
                ptr_esc_r <= ptr_esc_r;
            end
            if (pop_ef_s) begin
                ptr_lec_r <= ~ptr_lec_r;
            end else begin
                ptr_lec_r <= ptr_lec_r;
            end
            case ({push_ef_s, pop_ef_s})
                2'b10:   ocup_r <= ocup_r + 2'd1;
                2'b01:   ocup_r <= ocup_r - 2'd1;
                default: ocup_r <= ocup_r;
            endcase
        end
    end

    // Entry storage, written at the tail on an accepted push
    always_ff @(posedge clk) begin
        if (reinicio) begin
            mem_r[0] <= 64'd0;
            mem_r[1] <= 64'd0;
        end else if (push_ef_s) begin
            mem_r[ptr_esc_r] <= dato_entrada;
        end
    end

    // Head and occupancy are straight register reads
    always_comb begin
        dato_cabeza = mem_r[ptr_lec_r];
        ocupacion   = ocup_r;
    end

endmodule

// File: rtl/unidad_busqueda.sv
// Instruction fetch unit: keeps the fetch PC, issues at most one read to
// instruction memory at a time, buffers returned words in a 2-entry FIFO
// and offers the head to decode. A redirect flushes everything in flight;
// a response still outstanding at redirect time is dropped via DESCARTE.
module unidad_busqueda
    import paquete_busqueda::*;
(
    input  logic               clk,
    input  logic               reinicio,
    unidad_busqueda_if.master  bus
);

    estado_t     estado_r;
    logic [31:0] pc_actual_r;
    logic [31:0] pc_pend_r;

    logic [1:0]  ocupacion_s;
    logic [63:0] cabeza_raw_s;
    entrada_t    cabeza_s;
    logic        hay_dato_s;
    logic        pendiente_s;
    logic        aterriza_s;
    logic [2:0]  carga_s;
    logic        emite_s;
    logic        empuja_s;
    logic        saca_s;

    // Issue / push / pop decisions for this cycle
    always_comb begin
        pendiente_s = (estado_r != OCIOSO);
        aterriza_s  = (estado_r == ESPERA);
        // Occupancy once the outstanding response (if kept) lands; pops ignored
        carga_s     = {1'b0, ocupacion_s} + {2'b00, aterriza_s};
        emite_s     = 1'b0;
        if (bus.salto_valido) begin
            emite_s = 1'b0;
        end else begin
            case (estado_r)
                OCIOSO:   emite_s = (ocupacion_s < 2'd2);
                ESPERA:   emite_s = bus.mem_listo && (carga_s < 3'd2);
                DESCARTE: emite_s = bus.mem_listo && (carga_s < 3'd2);
                default:  emite_s = 1'b0;
            endcase
        end
        hay_dato_s = (ocupacion_s != 2'd0);
        empuja_s   = !bus.salto_valido && aterriza_s && bus.mem_listo;
        saca_s     = hay_dato_s && !bus.detener && !bus.salto_valido;
    end

    // Memory request: held low combinationally while reset is asserted
    always_comb begin
        bus.mem_req = emite_s && !reinicio;
        bus.mem_dir = pc_actual_r;
    end

    // Control FSM and fetch PC
    always_ff @(posedge clk) begin
        if (reinicio) begin
            estado_r    <= OCIOSO;
            pc_actual_r <= PC_REINICIO;
            pc_pend_r   <= PC_REINICIO;
        end else if (bus.salto_valido) begin
            pc_actual_r <= bus.salto_destino;
            pc_pend_r   <= pc_pend_r;
            if (pendiente_s && !bus.mem_listo) begin
                estado_r <= DESCARTE;
            end else begin
                estado_r <= OCIOSO;
            end
        end else if (emite_s) begin
            estado_r    <= ESPERA;
            pc_actual_r <= siguiente_pc(pc_actual_r);
            pc_pend_r   <= pc_actual_r;
        end else if (pendiente_s && bus.mem_listo) begin
            estado_r    <= OCIOSO;
            pc_actual_r <= pc_actual_r;
            pc_pend_r   <= pc_pend_r;
        end else begin
            estado_r    <= estado_r;
            pc_actual_r <= pc_actual_r;
            pc_pend_r   <= pc_pend_r;
        end
    end

    fifo_busqueda u_fifo (
        .clk          (clk),
        .reinicio     (reinicio),
        .push         (empuja_s),
        .pop          (saca_s),
        .flush        (bus.salto_valido),
        .dato_entrada ({pc_pend_r, bus.mem_dato}),
        .dato_cabeza  (cabeza_raw_s),
        .ocupacion    (ocupacion_s)
    );

    // Offer the FIFO head to decode; idle values when empty
    always_comb begin
        cabeza_s = entrada_t'(cabeza_raw_s);
        if (hay_dato_s) begin
            bus.valido_salida      = 1'b1;
            bus.instruccion_salida = cabeza_s.instr;
            bus.pc_salida          = cabeza_s.pc;
        end else begin
            bus.valido_salida      = 1'b0;
            bus.instruccion_salida = NOP;
            bus.pc_salida          = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_unidad_busqueda.sv
// Directed bench for unidad_busqueda. Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 time unit later, well before the next edge.
module tb_unidad_busqueda;

    logic clk = 1'b0;
    logic reinicio;
    int   checks   = 0;
    int   failures = 0;

    unidad_busqueda_if bi();

    unidad_busqueda dut (
        .clk      (clk),
        .reinicio (reinicio),
        .bus      (bi)
    );

    always #5 clk = ~clk;

    // Memory content model: each word is its address with a marker pattern
    function automatic logic [31:0] palabra(input logic [31:0] pc);
        return pc ^ 32'h1300_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        assert (obs === esp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, esp);
        end
    endtask

    task automatic pon(input logic r, input logic det, input logic sv,
                       input logic [31:0] sd, input logic ml, input logic [31:0] md);
        reinicio         = r;
        bi.detener       = det;
        bi.salto_valido  = sv;
        bi.salto_destino = sd;
        bi.mem_listo     = ml;
        bi.mem_dato      = md;
        #1;
    endtask

    task automatic siguiente();
        @(posedge clk);
        #1;
    endtask

    task automatic pide(input string tag, input logic [31:0] dir);
        chk({tag, "_req"}, {31'd0, bi.mem_req}, 32'd1);
        chk({tag, "_dir"}, bi.mem_dir, dir);
    endtask

    task automatic sin_pide(input string tag);
        chk({tag, "_noreq"}, {31'd0, bi.mem_req}, 32'd0);
    endtask

    task automatic salida(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, "_val"}, {31'd0, bi.valido_salida}, {31'd0, v});
        chk({tag, "_pc"}, bi.pc_salida, pc);
        chk({tag, "_ins"}, bi.instruccion_salida, ins);
    endtask

    task automatic resetea(input string tag);
        pon(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        sin_pide(tag);
        siguiente();
    endtask

    initial begin
        // ---- Streaming with mem_listo right after each request ----
        resetea("s1_rst");
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        salida("s1_reset_out", 1'b0, 32'd0, 32'd0);
        pide("s1_c1", 32'h0);
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, palabra(32'h0));
        salida("s1_c2", 1'b0, 32'd0, 32'd0);
        pide("s1_c2", 32'h4);
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, palabra(32'h4));
        salida("s1_c3", 1'b1, 32'h0, palabra(32'h0));
        sin_pide("s1_c3");
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        salida("s1_c4", 1'b1, 32'h4, palabra(32'h4));
        pide("s1_c4", 32'h8);
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, palabra(32'h8));
        salida("s1_c5", 1'b0, 32'd0, 32'd0);
        pide("s1_c5", 32'hC);
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, palabra(32'hC));
        salida("s1_c6", 1'b1, 32'h8, palabra(32'h8));
        sin_pide("s1_c6");
        siguiente();

        // ---- detener held for 6 cycles ----
        resetea("s2_rst");
        pon(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        pide("s2_c1", 32'h0);
        siguiente();
        pon(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, palabra(32'h0));
        pide("s2_c2", 32'h4);
        siguiente();
        pon(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, palabra(32'h4));
        salida("s2_c3", 1'b1, 32'h0, palabra(32'h0));
        sin_pide("s2_c3");
        siguiente();
        for (int k = 4; k <= 6; k++) begin
            pon(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
            salida("s2_hold", 1'b1, 32'h0, palabra(32'h0));
            sin_pide("s2_hold");
            siguiente();
        end
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        salida("s2_c7", 1'b1, 32'h0, palabra(32'h0));
        sin_pide("s2_c7");
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        salida("s2_c8", 1'b1, 32'h4, palabra(32'h4));
        pide("s2_c8", 32'h8);
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, palabra(32'h8));
        salida("s2_c9", 1'b0, 32'd0, 32'd0);
        pide("s2_c9", 32'hC);
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        salida("s2_c10", 1'b1, 32'h8, palabra(32'h8));
        sin_pide("s2_c10");
        siguiente();

        // ---- Redirect while the request to 8 is outstanding ----
        resetea("s3_rst");
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        pide("s3_c1", 32'h0);
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, palabra(32'h0));
        pide("s3_c2", 32'h4);
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, palabra(32'h4));
        sin_pide("s3_c3");
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        pide("s3_c4", 32'h8);
        siguiente();
        pon(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'd0);
        sin_pide("s3_salto");
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        salida("s3_after", 1'b0, 32'd0, 32'd0);
        sin_pide("s3_descarte_wait");
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, palabra(32'h8));
        salida("s3_late8", 1'b0, 32'd0, 32'd0);
        pide("s3_target", 32'h0000_0100);
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, palabra(32'h100));
        salida("s3_dropped", 1'b0, 32'd0, 32'd0);
        pide("s3_next", 32'h0000_0104);
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        salida("s3_out100", 1'b1, 32'h0000_0100, palabra(32'h100));
        siguiente();

        // ---- salto_valido and mem_listo together in ESPERA ----
        resetea("s4_rst");
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        pide("s4_c1", 32'h0);
        siguiente();
        pon(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1, palabra(32'h0));
        sin_pide("s4_salto");
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        salida("s4_empty", 1'b0, 32'd0, 32'd0);
        pide("s4_target", 32'h0000_0200);
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, palabra(32'h200));
        salida("s4_c4", 1'b0, 32'd0, 32'd0);
        pide("s4_c4", 32'h0000_0204);
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        salida("s4_out200", 1'b1, 32'h0000_0200, palabra(32'h200));
        siguiente();

        // ---- PC wrap at the top of the address space ----
        resetea("s5_rst");
        pon(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
        sin_pide("s5_salto");
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        pide("s5_top", 32'hFFFF_FFFC);
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, palabra(32'hFFFF_FFFC));
        pide("s5_wrap", 32'h0000_0000);
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        salida("s5_out", 1'b1, 32'hFFFF_FFFC, palabra(32'hFFFF_FFFC));
        siguiente();

        // ---- Reset in the middle of a request ----
        resetea("s6_rst");
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        pide("s6_c1", 32'h0);
        siguiente();
        pon(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        sin_pide("s6_inreset");
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF);
        salida("s6_after", 1'b0, 32'd0, 32'd0);
        pide("s6_restart", 32'h0);
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, palabra(32'h0));
        salida("s6_late_ignored", 1'b0, 32'd0, 32'd0);
        pide("s6_c4", 32'h4);
        siguiente();
        pon(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        salida("s6_out0", 1'b1, 32'h0, palabra(32'h0));
        siguiente();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unidad_busqueda.md
UNIDAD_BUSQUEDA -- requirements
Module: unidad_busqueda

Interface
REQ-001 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-002 The block SHALL have these ports:
- clk  in  1  clock; all state updates on its rising edge.
- reinicio  in  1  synchronous, active-high reset.
- detener  in  1  downstream pipeline register not accepting this cycle.
- salto_valido  in  1  redirect fetch to salto_destino.
- salto_destino  in  32  redirect target address.
- mem_req  out  1  instruction-memory read request; the memory accepts it in the same cycle.
- mem_dir  out  32  request address; meaningful only while mem_req=1.
- mem_listo  in  1  read data returned this cycle, no earlier than the cycle after mem_req.
- mem_dato  in  32  returned instruction word.
- instruccion_salida  out  32  instruction offered to the decode pipeline register.
- pc_salida  out  32  address of instruccion_salida.
- valido_salida  out  1  instruccion_salida/pc_salida hold a real instruction.

Function
REQ-003 The block SHALL keep a fetch PC register pc_actual, incremented by 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0) each time a request issues.
REQ-004 The block SHALL allow at most one outstanding memory request.
REQ-005 Control FSM SHALL have three states:
- OCIOSO: nothing outstanding.
- ESPERA: one request outstanding; its response is to be kept.
- DESCARTE: one request outstanding; its response is to be dropped.
REQ-006 The block SHALL buffer returned words with their PCs in a 2-entry FIFO; outputs SHALL be driven from the FIFO head.
REQ-007 While the FIFO is empty, outputs SHALL be valido_salida=0, instruccion_salida=NOP, pc_salida=0.
REQ-008 The head SHALL be popped only when valido_salida=1, detener=0 and salto_valido=0.
REQ-009 Issue condition (pops this cycle do not count): mem_req=1 with mem_dir=pc_actual only when salto_valido=0 and either
- state=OCIOSO and ocupacion<2, or
- state=ESPERA/DESCARTE with mem_listo=1 and ocupacion+landing<2 (landing=1 in ESPERA, 0 in DESCARTE).
REQ-010 On mem_listo in ESPERA, {pc, mem_dato} SHALL be pushed; in DESCARTE it SHALL be discarded; in OCIOSO mem_listo SHALL be ignored.
REQ-011 State transitions:
- Issue: next state ESPERA.
- mem_listo without issue: next state OCIOSO.
REQ-012 salto_valido=1 SHALL have priority over all other events and SHALL, in the same cycle:
- flush the FIFO;
- suppress the pop;
- suppress mem_req;
- load pc_actual <= salto_destino.
REQ-013 On salto_valido, next state SHALL be DESCARTE if a request is outstanding and mem_listo=0; otherwise OCIOSO.
REQ-014 Outputs SHALL show valido_salida=0 the cycle after a redirect; the first target request SHALL issue that cycle (if in OCIOSO).
REQ-015 detener=1 SHALL hold the FIFO head stable; fetch SHALL continue until the FIFO is full.
REQ-016 Best-case latency SHALL be: request at cycle N, mem_listo at N+1, valido_salida=1 at N+2.

Reset
REQ-017 When reinicio=1 at a clock edge, the block SHALL set:
- pc_actual=PC_REINICIO;
- FIFO empty;
- state=OCIOSO;
- mem_req=0 (combinationally, while reinicio is asserted);
- valido_salida=0, instruccion_salida=NOP, pc_salida=0.
REQ-018 A reset mid-request SHALL drop any later mem_listo arriving while in OCIOSO (per REQ-010).

Structure
REQ-019 Package paquete_busqueda SHALL hold:
- PC_REINICIO=32'h0000_0000;
- NOP=32'h0000_0000;
- PASO_PC=4;
- the FSM state type.
REQ-020 The 2-entry FIFO SHALL be a sub-module fifo_busqueda (64-bit entry, push/pop/flush, ocupacion 0..2).

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then mem_listo every cycle after request, detener=0: mem_dir sequence 0,4,8,C; outputs pc 0,4,8 with matching words, first valido_salida=1 two cycles after the first mem_req.
- detener held 6 cycles: at most 2 responses buffered, mem_req stays 0 afterwards, head pc stays 0; release: pcs 0,4,8 emerge in order, none lost or duplicated.
- Redirect to 32'h0000_0100 while a request to 8 is outstanding (mem_listo 2 cycles later): that response dropped, FSM passes through DESCARTE, next output pc=32'h100.
- salto_valido and mem_listo in the same cycle in ESPERA: word dropped, FIFO empty next cycle, request to target issues the following cycle.
- pc_actual=32'hFFFF_FFFC: mem_dir 32'hFFFF_FFFC then 32'h0000_0000.
- reinicio asserted mid-request: outputs NOP/0/0 next cycle, late mem_listo ignored, fetch restarts at 0.
